// File: rtl/grid_video_pkg.sv
// Shared timing, colour and grid-size defaults for the renderer and the upstream grid writer.
package grid_video_pkg;
    localparam int DEF_GRID_ROWS  = 30;
    localparam int DEF_GRID_COLS  = 40;
    localparam int DEF_CELL_SHIFT = 3;
    localparam int DEF_H_TOTAL    = 400;
    localparam int DEF_V_TOTAL    = 262;
    localparam int DEF_H_START    = 40;
    localparam int DEF_V_START    = 11;
    localparam int DEF_HS_POS     = 8;

    localparam logic [23:0] DEF_FG_COLOR = 24'hFFFFFF;
    localparam logic [23:0] DEF_BG_COLOR = 24'h000000;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic wrap;
    } vt_strobe_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/video_timing_gen.sv
// Free-running h/v raster counters with raw active, hsync, vsync and frame-wrap strobes.
module video_timing_gen
    import grid_video_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int H_START  = DEF_H_START,
    parameter int V_START  = DEF_V_START,
    parameter int H_ACTIVE = DEF_GRID_COLS << DEF_CELL_SHIFT,
    parameter int V_ACTIVE = DEF_GRID_ROWS << DEF_CELL_SHIFT,
    parameter int HS_POS   = DEF_HS_POS,
    localparam int HW = cnt_width(H_TOTAL + 1),
    localparam int VW = cnt_width(V_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output vt_strobe_t    strobe
);
    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        strobe.active = (h_cnt >= HW'(H_START)) && (h_cnt < HW'(H_START + H_ACTIVE)) &&
                        (v_cnt >= VW'(V_START)) && (v_cnt < VW'(V_START + V_ACTIVE));
        strobe.hs     = (h_cnt == HW'(HS_POS));
        strobe.vs     = (h_cnt == '0) && (v_cnt == '0);
        strobe.wrap   = h_last && v_last;
    end
endmodule

// File: rtl/grid_renderer.sv
// Renders a 1-bit-per-cell grid bitmap as a video raster; the bitmap is snapshotted once per
// frame at the raster wrap so the displayed frame never tears.
module grid_renderer
    import grid_video_pkg::*;
#(
    parameter int          GRID_ROWS  = DEF_GRID_ROWS,
    parameter int          GRID_COLS  = DEF_GRID_COLS,
    parameter int          CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int          H_TOTAL    = DEF_H_TOTAL,
    parameter int          V_TOTAL    = DEF_V_TOTAL,
    parameter int          H_START    = DEF_H_START,
    parameter int          V_START    = DEF_V_START,
    parameter int          HS_POS     = DEF_HS_POS,
    parameter logic [23:0] FG_COLOR   = DEF_FG_COLOR,
    parameter logic [23:0] BG_COLOR   = DEF_BG_COLOR
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [GRID_ROWS*GRID_COLS-1:0] grid_ram,
    output logic [23:0]                    vid_rgb,
    output logic                           vid_de,
    output logic                           vid_hs,
    output logic                           vid_vs,
    output logic                           frame_latched
);
    localparam int CELLS = GRID_ROWS * GRID_COLS;
    localparam int IDX_W = cnt_width(CELLS);
    localparam int HW    = cnt_width(H_TOTAL + 1);
    localparam int VW    = cnt_width(V_TOTAL + 1);

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    vt_strobe_t       strobe;
    logic [HW-1:0]    px;
    logic [VW-1:0]    py;
    logic [IDX_W-1:0] cell_idx;
    logic [IDX_W-1:0] cell_idx_q;
    logic             active_q;
    logic             hs_q;
    logic             vs_q;
    logic [CELLS-1:0] shadow;

    video_timing_gen #(
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .H_START  (H_START),
        .V_START  (V_START),
        .H_ACTIVE (GRID_COLS << CELL_SHIFT),
        .V_ACTIVE (GRID_ROWS << CELL_SHIFT),
        .HS_POS   (HS_POS)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .strobe (strobe)
    );

    // Index is forced to 0 outside the active window so the shadow lookup never leaves range.
    always_comb begin
        px       = h_cnt - HW'(H_START);
        py       = v_cnt - VW'(V_START);
        cell_idx = '0;
        if (strobe.active) begin
            cell_idx = IDX_W'(py >> CELL_SHIFT) * IDX_W'(GRID_COLS) + IDX_W'(px >> CELL_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow        <= '0;
            frame_latched <= 1'b0;
            cell_idx_q    <= '0;
            active_q      <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            vid_rgb       <= 24'h000000;
            vid_de        <= 1'b0;
            vid_hs        <= 1'b0;
            vid_vs        <= 1'b0;
        end else begin
            frame_latched <= strobe.wrap;
            if (strobe.wrap) begin
                shadow <= grid_ram;
            end
            cell_idx_q <= cell_idx;
            active_q   <= strobe.active;
            hs_q       <= strobe.hs;
            vs_q       <= strobe.vs;
            vid_de     <= active_q;
            vid_hs     <= hs_q;
            vid_vs     <= vs_q;
            vid_rgb    <= active_q ? (shadow[cell_idx_q] ? FG_COLOR : BG_COLOR) : 24'h000000;
        end
    end
endmodule
